// File: rtl/fft_radix4_butterfly_pkg.sv
// rtl/fft_radix4_butterfly_pkg.sv - shared FFT constants: data width, rounding constant, scaling shift
package fft_radix4_butterfly_pkg;

   // Default signed width of every real/imag sample in the FFT core
   localparam int FFT_BIT   = 17;
   // Half-LSB of the /4 result, added before the shift for round-half-up
   localparam int FFT_RND   = 2;
   // Fixed /4 scaling that absorbs the radix-4 word growth
   localparam int FFT_SHIFT = 2;

endpackage

// File: rtl/fft_add4_round.sv
// rtl/fft_add4_round.sv - signed 4-operand add/subtract with /4 round-half-up scaling
//
// Purpose: computes floor((+-a +-b +-c +-d + 2) / 4) in BIT+2-bit modular arithmetic.
// Ports:
//   i_a..i_d  signed BIT-bit operands
//   i_neg     per-operand subtract select, bit 0 -> i_a ... bit 3 -> i_d
//   o_y       signed BIT-bit scaled result (combinational)
module fft_add4_round
   import fft_radix4_butterfly_pkg::*;
#(
   parameter int BIT = FFT_BIT
)
(
   input  logic signed [BIT-1:0] i_a,
   input  logic signed [BIT-1:0] i_b,
   input  logic signed [BIT-1:0] i_c,
   input  logic signed [BIT-1:0] i_d,
   input  logic        [3:0]     i_neg,
   output logic signed [BIT-1:0] o_y
);

   localparam int W = BIT + 2;

   logic signed [W-1:0] w_a, w_b, w_c, w_d;
   logic signed [W-1:0] w_ta, w_tb, w_tc, w_td;
   logic signed [W-1:0] w_sum;

   assign w_a = {{2{i_a[BIT-1]}}, i_a};
   assign w_b = {{2{i_b[BIT-1]}}, i_b};
   assign w_c = {{2{i_c[BIT-1]}}, i_c};
   assign w_d = {{2{i_d[BIT-1]}}, i_d};

   // Negation wraps modulo 2^W; only a most-negative operand can overflow here
   assign w_ta = i_neg[0] ? -w_a : w_a;
   assign w_tb = i_neg[1] ? -w_b : w_b;
   assign w_tc = i_neg[2] ? -w_c : w_c;
   assign w_td = i_neg[3] ? -w_d : w_d;

   assign w_sum = w_ta + w_tb + w_tc + w_td + W'(FFT_RND);

   // Arithmetic shift then truncate: equals bits [BIT+1:2] of the sum
   assign o_y = BIT'(w_sum >>> FFT_SHIFT);

endmodule

// File: rtl/fft_radix4_butterfly.sv
// rtl/fft_radix4_butterfly.sv - radix-4 DFT butterfly, outputs scaled by 1/4, one register stage
//
// Purpose: y_k = (sum_n x_n * (-j)^(n*k) + 2) >> 2 for k = 0..3, registered once.
// Ports:
//   iCLK           rising-edge clock
//   iRESET         asynchronous active-low reset, clears all outputs
//   iXn_RE/iXn_IM  signed complex input samples x0..x3
//   oYk_RE/oYk_IM  signed registered complex outputs y0..y3 (latency 1)
module fft_radix4_butterfly
   import fft_radix4_butterfly_pkg::*;
#(
   parameter int BIT = FFT_BIT
)
(
   input  logic                  iCLK,
   input  logic                  iRESET,
   input  logic signed [BIT-1:0] iX0_RE,
   input  logic signed [BIT-1:0] iX0_IM,
   input  logic signed [BIT-1:0] iX1_RE,
   input  logic signed [BIT-1:0] iX1_IM,
   input  logic signed [BIT-1:0] iX2_RE,
   input  logic signed [BIT-1:0] iX2_IM,
   input  logic signed [BIT-1:0] iX3_RE,
   input  logic signed [BIT-1:0] iX3_IM,
   output logic signed [BIT-1:0] oY0_RE,
   output logic signed [BIT-1:0] oY0_IM,
   output logic signed [BIT-1:0] oY1_RE,
   output logic signed [BIT-1:0] oY1_IM,
   output logic signed [BIT-1:0] oY2_RE,
   output logic signed [BIT-1:0] oY2_IM,
   output logic signed [BIT-1:0] oY3_RE,
   output logic signed [BIT-1:0] oY3_IM
);

   // Index 2k is Re(y_k), 2k+1 is Im(y_k)
   logic signed [BIT-1:0] w_y [0:7];
   logic signed [BIT-1:0] r_y [0:7];

   // Multiplying by -j swaps re/im, so odd-k terms mix real and imaginary inputs.
   // i_neg bit order is {d, c, b, a}.
   fft_add4_round #(.BIT(BIT)) u_s0re (.i_a(iX0_RE), .i_b(iX1_RE), .i_c(iX2_RE), .i_d(iX3_RE), .i_neg(4'b0000), .o_y(w_y[0]));
   fft_add4_round #(.BIT(BIT)) u_s0im (.i_a(iX0_IM), .i_b(iX1_IM), .i_c(iX2_IM), .i_d(iX3_IM), .i_neg(4'b0000), .o_y(w_y[1]));
   fft_add4_round #(.BIT(BIT)) u_s1re (.i_a(iX0_RE), .i_b(iX1_IM), .i_c(iX2_RE), .i_d(iX3_IM), .i_neg(4'b1100), .o_y(w_y[2]));
   fft_add4_round #(.BIT(BIT)) u_s1im (.i_a(iX0_IM), .i_b(iX1_RE), .i_c(iX2_IM), .i_d(iX3_RE), .i_neg(4'b0110), .o_y(w_y[3]));
   fft_add4_round #(.BIT(BIT)) u_s2re (.i_a(iX0_RE), .i_b(iX1_RE), .i_c(iX2_RE), .i_d(iX3_RE), .i_neg(4'b1010), .o_y(w_y[4]));
   fft_add4_round #(.BIT(BIT)) u_s2im (.i_a(iX0_IM), .i_b(iX1_IM), .i_c(iX2_IM), .i_d(iX3_IM), .i_neg(4'b1010), .o_y(w_y[5]));
   fft_add4_round #(.BIT(BIT)) u_s3re (.i_a(iX0_RE), .i_b(iX1_IM), .i_c(iX2_RE), .i_d(iX3_IM), .i_neg(4'b0110), .o_y(w_y[6]));
   fft_add4_round #(.BIT(BIT)) u_s3im (.i_a(iX0_IM), .i_b(iX1_RE), .i_c(iX2_IM), .i_d(iX3_RE), .i_neg(4'b1100), .o_y(w_y[7]));

   always_ff @(posedge iCLK or negedge iRESET) begin
      if (!iRESET) begin
         for (int i = 0; i < 8; i++) r_y[i] <= '0;
      end else begin
         for (int i = 0; i < 8; i++) r_y[i] <= w_y[i];
      end
   end

   assign oY0_RE = r_y[0];
   assign oY0_IM = r_y[1];
   assign oY1_RE = r_y[2];
   assign oY1_IM = r_y[3];
   assign oY2_RE = r_y[4];
   assign oY2_IM = r_y[5];
   assign oY3_RE = r_y[6];
   assign oY3_IM = r_y[7];

endmodule

// File: tb/tb_fft_radix4_butterfly.sv
// tb/tb_fft_radix4_butterfly.sv - scoreboard bench for the radix-4 butterfly
module tb_fft_radix4_butterfly;

   localparam int BIT = 17;

   logic iCLK = 1'b0;
   logic iRESET;
   logic signed [BIT-1:0] iX0_RE, iX0_IM, iX1_RE, iX1_IM, iX2_RE, iX2_IM, iX3_RE, iX3_IM;
   logic signed [BIT-1:0] oY0_RE, oY0_IM, oY1_RE, oY1_IM, oY2_RE, oY2_IM, oY3_RE, oY3_IM;

   int total = 0;
   int bad   = 0;
   int exp_q [$];

   always #5 iCLK = ~iCLK;

   fft_radix4_butterfly #(.BIT(BIT)) dut (
      .iCLK(iCLK), .iRESET(iRESET),
      .iX0_RE(iX0_RE), .iX0_IM(iX0_IM), .iX1_RE(iX1_RE), .iX1_IM(iX1_IM),
      .iX2_RE(iX2_RE), .iX2_IM(iX2_IM), .iX3_RE(iX3_RE), .iX3_IM(iX3_IM),
      .oY0_RE(oY0_RE), .oY0_IM(oY0_IM), .oY1_RE(oY1_RE), .oY1_IM(oY1_IM),
      .oY2_RE(oY2_RE), .oY2_IM(oY2_IM), .oY3_RE(oY3_RE), .oY3_IM(oY3_IM)
   );

   function automatic int sext(input int v);
      return ((v & 'h1FFFF) ^ 'h10000) - 'h10000;
   endfunction

   task automatic check(input string name, input int act, input int expv);
      total++;
      if (act !== expv) begin
         bad++;
         $display("FAIL %s actual=%0d required=%0d", name, act, expv);
      end
   endtask

   // Reference: direct DFT with twiddles (-j)^(n*k), then floor((S+2)/4)
   task automatic push_model(input int xr [4], input int xi [4]);
      for (int k = 0; k < 4; k++) begin
         int sr = 0;
         int si = 0;
         for (int n = 0; n < 4; n++) begin
            case ((n * k) % 4)
               0: begin sr += xr[n]; si += xi[n]; end
               1: begin sr += xi[n]; si -= xr[n]; end
               2: begin sr -= xr[n]; si -= xi[n]; end
               default: begin sr -= xi[n]; si += xr[n]; end
            endcase
         end
         exp_q.push_back(sext((sr + 2) >>> 2));
         exp_q.push_back(sext((si + 2) >>> 2));
      end
   endtask

   task automatic apply(input int r0, input int i0, input int r1, input int i1,
                        input int r2, input int i2, input int r3, input int i3);
      int xr [4];
      int xi [4];
      @(negedge iCLK);
      xr[0] = r0; xr[1] = r1; xr[2] = r2; xr[3] = r3;
      xi[0] = i0; xi[1] = i1; xi[2] = i2; xi[3] = i3;
      iX0_RE = BIT'(r0); iX0_IM = BIT'(i0);
      iX1_RE = BIT'(r1); iX1_IM = BIT'(i1);
      iX2_RE = BIT'(r2); iX2_IM = BIT'(i2);
      iX3_RE = BIT'(r3); iX3_IM = BIT'(i3);
      push_model(xr, xi);
   endtask

   task automatic unit_sample(output int re, output int im);
      real s;
      re = int'($urandom_range(0, 65534)) - 32767;
      s  = $sqrt(32768.0 * 32768.0 - real'(re) * real'(re));
      im = $rtoi(s + 0.5);
      if ($urandom_range(0, 1) == 1) im = -im;
   endtask

   task automatic check_all_zero(input string name);
      check({name, "_y0re"}, int'(oY0_RE), 0);
      check({name, "_y0im"}, int'(oY0_IM), 0);
      check({name, "_y1re"}, int'(oY1_RE), 0);
      check({name, "_y1im"}, int'(oY1_IM), 0);
      check({name, "_y2re"}, int'(oY2_RE), 0);
      check({name, "_y2im"}, int'(oY2_IM), 0);
      check({name, "_y3re"}, int'(oY3_RE), 0);
      check({name, "_y3im"}, int'(oY3_IM), 0);
   endtask

   // Monitor: a vector driven at a falling edge is captured at the next rising edge
   initial begin
      int act [8];
      forever begin
         @(posedge iCLK);
         #2;
         if (exp_q.size() >= 8) begin
            act[0] = int'(oY0_RE); act[1] = int'(oY0_IM);
            act[2] = int'(oY1_RE); act[3] = int'(oY1_IM);
            act[4] = int'(oY2_RE); act[5] = int'(oY2_IM);
            act[6] = int'(oY3_RE); act[7] = int'(oY3_IM);
            for (int i = 0; i < 8; i++) begin
               int e;
               e = exp_q.pop_front();
               check($sformatf("y%0d%s", i / 2, (i % 2 == 0) ? "re" : "im"), act[i], e);
            end
         end
      end
   end

   initial begin
      int r [4];
      int m [4];
      iRESET = 1'b0;
      iX0_RE = 17'sd100;  iX0_IM = -17'sd50;
      iX1_RE = 17'sd7;    iX1_IM = 17'sd9;
      iX2_RE = -17'sd300; iX2_IM = 17'sd11;
      iX3_RE = 17'sd12;   iX3_IM = -17'sd13;
      repeat (3) @(posedge iCLK);
      #2;
      check_all_zero("rst");

      @(negedge iCLK);
      iRESET = 1'b1;
      apply(4, 0, 0, 0, 0, 0, 0, 0);
      apply(0, 0, 0, 8, 0, 0, 0, 0);
      apply(2, -2, 0, 0, 0, 0, 0, 0);
      apply(1, -3, 0, 0, 0, 0, 0, 0);
      apply(32768, 0, 32768, 0, 32768, 0, 32768, 0);
      apply(0, -32768, 0, -32768, 0, -32768, 0, -32768);

      // Back-to-back random unit-magnitude vectors, one per cycle
      for (int v = 0; v < 35; v++) begin
         for (int n = 0; n < 4; n++) unit_sample(r[n], m[n]);
         apply(r[0], m[0], r[1], m[1], r[2], m[2], r[3], m[3]);
      end

      repeat (3) @(posedge iCLK);
      check("drain1", exp_q.size(), 0);

      // Asynchronous reset in the middle of a cycle clears outputs immediately
      @(posedge iCLK);
      #3;
      iRESET = 1'b0;
      #1;
      check_all_zero("arst");
      repeat (2) @(posedge iCLK);
      #2;
      check_all_zero("arst_hold");

      @(negedge iCLK);
      iRESET = 1'b1;
      apply(-4, 4, 8, 0, 0, -8, 3, 5);
      for (int v = 0; v < 4; v++) begin
         for (int n = 0; n < 4; n++) unit_sample(r[n], m[n]);
         apply(r[0], m[0], r[1], m[1], r[2], m[2], r[3], m[3]);
      end

      repeat (3) @(posedge iCLK);
      check("drain2", exp_q.size(), 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
